wb_retire_queue: RTL and testbench
==================================

# wb_retire_queue

In-order writeback retirement queue for the RISC-V pipeline. It is the producer of the `we`/`rdwbs` writeback events that the register hazard tracker consumes. Each register-writing instruction is entered at issue, tagged, and marked complete when its functional unit returns a result; completion may be out of order. Completed results are retired strictly in issue order, one per cycle, driving the register-file write port and the tracker's pending-write decrement.

## Interface
Parameters:
- `DEPTH`, 4: number of queue entries (power of two, ≥2).
- `TAGW`, 2: tag width, log2(`DEPTH`).
- `regsel`, 5: register-select width.
- `XLEN`, 32: data width.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `iss_v`  in  1  issue request for an instruction with a valid destination.
- `iss_rd`  in  `regsel`  destination register of the issuing instruction.
- `iss_tag`  out  `TAGW`  tag that an issue this cycle receives (combinational, equals tail pointer).
- `full`  out  1  no free entry; the issue stage must not issue.
- `empty`  out  1  no valid entries.
- `cmp_v`  in  1  completion strobe from a functional unit.
- `cmp_tag`  in  `TAGW`  tag of the completing entry.
- `cmp_data`  in  `XLEN`  result value.
- `we`  out  1  registered writeback strobe, one cycle per retired entry.
- `rdwbs`  out  `regsel`  registered writeback destination.
- `wbdata`  out  `XLEN`  registered writeback data.
- `err`  out  1  sticky protocol-violation flag.

## Operation
- Entry state: `valid`, `done`, `rd`, `data`. Pointers `head` and `tail` are `TAGW` bits wide and wrap modulo `DEPTH`. `count` is `TAGW+1` bits.
- `full` = (`count`==`DEPTH`). `empty` = (`count`==0). Both are decoded from registered `count`.
- **Push.** `iss_v`=1, `iss_rd`≠0 and `full`=0:
  - entry[`tail`] gets valid=1, done=0, rd=`iss_rd`.
  - `tail` increments.
- **Push with `iss_rd`=0.** Not enqueued, no tag consumed, not an error. Register x0 is never tracked.
- **Push while `full`=1.** Dropped and `err` is set. A pop in the same cycle does not make room; `full` is evaluated on registered state.
- **Completion.** `cmp_v`=1 and entry[`cmp_tag`] has valid=1, done=0: the entry gets done=1 and data=`cmp_data`.
- **Bad completion.** A completion to an invalid entry or an already-done entry is ignored and sets `err`.
- **Retire.** When entry[`head`] has valid=1 and done=1 on a rising edge:
  - the entry is cleared and `head` increments;
  - `we`←1, `rdwbs`←rd, `wbdata`←data.
  - Otherwise `we`←0, and `rdwbs`/`wbdata` hold their previous values.
- **Same-edge push and retire.** Both take effect; `count` is unchanged.
- **Same-edge completion and retire on the same entry.** The completion lands first; retirement happens on the following edge. There is no bypass.
- **Head-of-line blocking.** A done entry behind a not-done head waits.
- `err` clears only on reset.

## Timing
- Reset (asynchronous assert, synchronous release):
  - all entries valid=0, done=0;
  - `head`=`tail`=`count`=0;
  - `we`=0, `rdwbs`=0, `wbdata`=0, `err`=0;
  - `full`=0, `empty`=1, `iss_tag`=0.
- Reset asserted mid-operation discards every entry immediately, with no writeback. The tracker is reset by the same `rst`.
- Push accepted at edge N: `empty`/`full`/`iss_tag` reflect it in cycle N+1.
- Minimum latency is 2 edges from completion to writeback:
  - `cmp_v` sampled at edge N sets done;
  - retire at edge N+1;
  - `we`=1 during cycle N+1→N+2.
- Throughput: at most one retire per cycle. Consecutive done entries produce back-to-back `we` pulses.
- `iss_tag` must be captured by the issuer in the same cycle as `iss_v`.

## Test plan
- **Reset and single write.**
  - Stimulus: reset; issue rd=5 (tag 0); complete tag 0 with 0xDEADBEEF one cycle later.
  - Required: `we` pulses exactly once with `rdwbs`=5 and `wbdata`=0xDEADBEEF, 2 edges after completion; `empty`=1 afterwards.
- **Out-of-order completion.**
  - Stimulus: issue rd=1,2,3 (tags 0,1,2); complete in order tag 2, 1, 0.
  - Required: no `we` until tag 0 completes, then three consecutive `we` cycles with `rdwbs`=1,2,3.
- **Full and wrap-around.**
  - Stimulus: issue 4 entries, giving `full`=1; issue rd=7 while full.
  - Required: the extra issue is dropped and `err`=1.
  - Then: complete and retire all 4, and issue 4 more.
  - Required: tags wrap 0..3 and retire order is preserved.
- **Simultaneous push and pop.**
  - Stimulus: with `count`=2 and head done, issue at the same edge the head retires.
  - Required: `count` stays at 2 and the new entry takes tag = old `tail`.
- **x0 and bad completions.**
  - Stimulus: issue rd=0.
  - Required: no entry, `iss_tag` unchanged, `err`=0.
  - Stimulus: complete an invalid tag, then complete a done tag twice.
  - Required: `err`=1 and entry data is unchanged.
- **Reset mid-flight.**
  - Stimulus: with 3 entries pending (one done), assert `rst` between edges.
  - Required: outputs return to reset values immediately, and no `we` follows release.

Source files
------------

// File: rtl/wb_retire_queue_if.sv
`default_nettype none
// ============================================================================
//  Module   : wb_retire_queue_if
//  Purpose  : Issue, completion and writeback signal bundle of the in-order
//             writeback retirement queue.
//  Revision : 1.0 - initial release
// ============================================================================
interface wb_retire_queue_if #(
    parameter int DEPTH  = 4,
    parameter int TAGW   = 2,
    parameter int REGSEL = 5,
    parameter int XLEN   = 32
);
    // issue side
    logic              iss_v;
    logic [REGSEL-1:0] iss_rd;
    logic [TAGW-1:0]   iss_tag;
    logic              full;
    logic              empty;
    // completion side
    logic              cmp_v;
    logic [TAGW-1:0]   cmp_tag;
    logic [XLEN-1:0]   cmp_data;
    // writeback side
    logic              we;
    logic [REGSEL-1:0] rdwbs;
    logic [XLEN-1:0]   wbdata;
    logic              err;

    // pipeline / functional units drive issue and completion
    modport master (
        output iss_v, iss_rd, cmp_v, cmp_tag, cmp_data,
        input  iss_tag, full, empty, we, rdwbs, wbdata, err
    );

    // retirement queue
    modport slave (
        input  iss_v, iss_rd, cmp_v, cmp_tag, cmp_data,
        output iss_tag, full, empty, we, rdwbs, wbdata, err
    );
endinterface
`default_nettype wire

// File: rtl/wb_retire_queue.sv
`default_nettype none
// ============================================================================
//  Module   : wb_retire_queue
//  Purpose  : In-order writeback retirement queue. Register-writing
//             instructions are tagged at issue, completed out of order and
//             retired strictly in issue order, one per cycle, onto the
//             register-file write port.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_retire_queue #(
    parameter int DEPTH  = 4,
    parameter int TAGW   = 2,
    parameter int REGSEL = 5,
    parameter int XLEN   = 32
) (
    input  wire logic          clk,
    input  wire logic          rst,      // asynchronous, active-low
    wb_retire_queue_if.slave   bus
);

    localparam logic [TAGW:0]   c_FULL_COUNT = (TAGW+1)'(DEPTH);
    localparam logic [TAGW:0]   c_COUNT_ONE  = (TAGW+1)'(1);
    localparam logic [TAGW-1:0] c_PTR_ONE    = TAGW'(1);

    // entry storage
    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_done;
    logic [REGSEL-1:0] r_rd   [DEPTH];
    logic [XLEN-1:0]   r_data [DEPTH];

    // pointers and occupancy
    logic [TAGW-1:0]   r_head;
    logic [TAGW-1:0]   r_tail;
    logic [TAGW:0]     r_count;

    // writeback port and error flag
    logic              r_we;
    logic [REGSEL-1:0] r_rdwbs;
    logic [XLEN-1:0]   r_wbdata;
    logic              r_err;

    logic              w_full;
    logic              w_push;
    logic              w_push_err;
    logic              w_cmp_ok;
    logic              w_cmp_err;
    logic              w_retire;

    // Decode status from registered state and qualify this cycle's requests.
    // Register x0 is never tracked, so an x0 issue is neither pushed nor an
    // error. A retire on this edge does not free room for a push on the
    // same edge because full comes from the registered count.
    always_comb begin
        w_full     = (r_count == c_FULL_COUNT);
        w_push     = bus.iss_v && (bus.iss_rd != '0) && !w_full;
        w_push_err = bus.iss_v && (bus.iss_rd != '0) &&  w_full;
        w_cmp_ok   = bus.cmp_v && r_valid[bus.cmp_tag] && !r_done[bus.cmp_tag];
        w_cmp_err  = bus.cmp_v && !w_cmp_ok;
        w_retire   = r_valid[r_head] && r_done[r_head];
    end

    assign bus.full    = w_full;
    assign bus.empty   = (r_count == '0);
    assign bus.iss_tag = r_tail;
    assign bus.we      = r_we;
    assign bus.rdwbs   = r_rdwbs;
    assign bus.wbdata  = r_wbdata;
    assign bus.err     = r_err;

    // Entry updates. Push, completion and retire can never address the same
    // entry on one edge: a push targets an invalid entry, a completion needs
    // a valid not-done entry and a retire needs a done entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
            r_done  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_rd[i]   <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_done[r_tail]  <= 1'b0;
                r_rd[r_tail]    <= bus.iss_rd;
            end
            if (w_cmp_ok) begin
                r_done[bus.cmp_tag] <= 1'b1;
                r_data[bus.cmp_tag] <= bus.cmp_data;
            end
            if (w_retire) begin
                r_valid[r_head] <= 1'b0;
                r_done[r_head]  <= 1'b0;
            end
        end
    end

    // Pointer and occupancy tracking; simultaneous push and retire cancel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + c_PTR_ONE;
            end
            if (w_retire) begin
                r_head <= r_head + c_PTR_ONE;
            end
            if (w_push && !w_retire) begin
                r_count <= r_count + c_COUNT_ONE;
            end else if (!w_push && w_retire) begin
                r_count <= r_count - c_COUNT_ONE;
            end
        end
    end

    // Registered writeback port; destination and data hold between retires.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we     <= 1'b0;
            r_rdwbs  <= '0;
            r_wbdata <= '0;
        end else begin
            r_we <= w_retire;
            if (w_retire) begin
                r_rdwbs  <= r_rd[r_head];
                r_wbdata <= r_data[r_head];
            end
        end
    end

    // Sticky protocol-violation flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (w_push_err || w_cmp_err) begin
            r_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_retire_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_retire_queue
//  Purpose  : Self-checking bench for wb_retire_queue: per-cycle vector
//             table plus hand sequences, with a writeback scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_retire_queue;

    logic clk;
    logic rst;

    wb_retire_queue_if #(.DEPTH(4), .TAGW(2), .REGSEL(5), .XLEN(32)) bus ();

    wb_retire_queue #(.DEPTH(4), .TAGW(2), .REGSEL(5), .XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // one cycle: inputs, expected accept flags, expected status after the edge
    typedef struct {
        logic        iv;
        logic [4:0]  rd;
        logic        cv;
        logic [1:0]  ct;
        logic [31:0] cd;
        logic        ap;     // issue is expected to be accepted
        logic        ac;     // completion is expected to be accepted
        logic        we;
        logic [1:0]  tag;
        logic        full;
        logic        empty;
        logic        err;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [1:0]  m_tag;
    logic [4:0]  m_rd   [4];
    logic [31:0] m_data [4];
    logic [1:0]  sb_q   [$];
    vec_t        tbl    [$];

    function automatic vec_t V(int iv, int rd, int cv, int ct, int cd, int ap, int ac,
                               int we, int tag, int full, int empty, int err);
        vec_t v;
        v.iv = 1'(iv);   v.rd = 5'(rd);   v.cv = 1'(cv);     v.ct = 2'(ct);
        v.cd = 32'(cd);  v.ap = 1'(ap);   v.ac = 1'(ac);     v.we = 1'(we);
        v.tag = 2'(tag); v.full = 1'(full); v.empty = 1'(empty); v.err = 1'(err);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // drive one cycle, update the scoreboard, check status and writebacks
    task automatic step(input vec_t v, input string nm);
        logic [1:0] t;
        bus.iss_v    = v.iv;
        bus.iss_rd   = v.rd;
        bus.cmp_v    = v.cv;
        bus.cmp_tag  = v.ct;
        bus.cmp_data = v.cd;
        if (v.ap) begin
            sb_q.push_back(m_tag);
            m_rd[m_tag] = v.rd;
        end
        if (v.ac) m_data[v.ct] = v.cd;
        @(posedge clk);
        #1;
        bus.iss_v = 1'b0;
        bus.cmp_v = 1'b0;
        chk({nm, ".we"},    32'(bus.we),      32'(v.we));
        chk({nm, ".tag"},   32'(bus.iss_tag), 32'(v.tag));
        chk({nm, ".full"},  32'(bus.full),    32'(v.full));
        chk({nm, ".empty"}, 32'(bus.empty),   32'(v.empty));
        chk({nm, ".err"},   32'(bus.err),     32'(v.err));
        if (bus.we === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s.sb: got writeback rd=%0d, expected none", nm, bus.rdwbs);
            end else begin
                t = sb_q.pop_front();
                chk({nm, ".rdwbs"},  32'(bus.rdwbs), 32'(m_rd[t]));
                chk({nm, ".wbdata"}, bus.wbdata,     m_data[t]);
            end
        end
        m_tag = v.tag;
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, ".we"},     32'(bus.we),      32'd0);
        chk({nm, ".rdwbs"},  32'(bus.rdwbs),   32'd0);
        chk({nm, ".wbdata"}, bus.wbdata,       32'd0);
        chk({nm, ".err"},    32'(bus.err),     32'd0);
        chk({nm, ".full"},   32'(bus.full),    32'd0);
        chk({nm, ".empty"},  32'(bus.empty),   32'd1);
        chk({nm, ".tag"},    32'(bus.iss_tag), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        sb_q.delete();
        m_tag = 2'd0;
        chk_reset_outputs("reset");
    endtask

    initial begin
        rst          = 1'b0;
        bus.iss_v    = 1'b0;
        bus.iss_rd   = '0;
        bus.cmp_v    = 1'b0;
        bus.cmp_tag  = '0;
        bus.cmp_data = '0;
        m_tag        = 2'd0;

        //            iv rd cv ct cd            ap ac we tag fl em er
        // single write
        tbl.push_back(V(1, 5, 0,0,0,            1, 0, 0, 1, 0, 0, 0));
        tbl.push_back(V(0, 0, 0,0,0,            0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(V(0, 0, 1,0,32'hDEADBEEF, 0, 1, 0, 1, 0, 0, 0));
        tbl.push_back(V(0, 0, 0,0,0,            0, 0, 1, 1, 0, 1, 0));
        tbl.push_back(V(0, 0, 0,0,0,            0, 0, 0, 1, 0, 1, 0));
        // out-of-order completion (tags 1,2,3 completed 3,2,1)
        tbl.push_back(V(1, 1, 0,0,0,            1, 0, 0, 2, 0, 0, 0));
        tbl.push_back(V(1, 2, 0,0,0,            1, 0, 0, 3, 0, 0, 0));
        tbl.push_back(V(1, 3, 0,0,0,            1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V(0, 0, 1,3,32'h33,       0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(V(0, 0, 1,2,32'h22,       0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(V(0, 0, 1,1,32'h11,       0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(V(0, 0, 0,0,0,            0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(V(0, 0, 0,0,0,            0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(V(0, 0, 0,0,0,            0, 0, 1, 0, 0, 1, 0));
        tbl.push_back(V(0, 0, 0,0,0,            0, 0, 0, 0, 0, 1, 0));
        // x0 issue: no entry, no tag, no error
        tbl.push_back(V(1, 0, 0,0,0,            0, 0, 0, 0, 0, 1, 0));
        // fill, overflow, drain
        tbl.push_back(V(1,10, 0,0,0,            1, 0, 0, 1, 0, 0, 0));
        tbl.push_back(V(1,11, 0,0,0,            1, 0, 0, 2, 0, 0, 0));
        tbl.push_back(V(1,12, 0,0,0,            1, 0, 0, 3, 0, 0, 0));
        tbl.push_back(V(1,13, 0,0,0,            1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(V(1, 7, 0,0,0,            0, 0, 0, 0, 1, 0, 1));
        tbl.push_back(V(0, 0, 1,0,32'hA0,       0, 1, 0, 0, 1, 0, 1));
        tbl.push_back(V(0, 0, 1,1,32'hA1,       0, 1, 1, 0, 0, 0, 1));
        tbl.push_back(V(0, 0, 1,2,32'hA2,       0, 1, 1, 0, 0, 0, 1));
        tbl.push_back(V(0, 0, 1,3,32'hA3,       0, 1, 1, 0, 0, 0, 1));
        tbl.push_back(V(0, 0, 0,0,0,            0, 0, 1, 0, 0, 1, 1));
        // wrap: four more entries reuse tags 0..3
        tbl.push_back(V(1,20, 0,0,0,            1, 0, 0, 1, 0, 0, 1));
        tbl.push_back(V(1,21, 0,0,0,            1, 0, 0, 2, 0, 0, 1));
        tbl.push_back(V(1,22, 0,0,0,            1, 0, 0, 3, 0, 0, 1));
        tbl.push_back(V(1,23, 0,0,0,            1, 0, 0, 0, 1, 0, 1));
        tbl.push_back(V(0, 0, 1,0,32'hB0,       0, 1, 0, 0, 1, 0, 1));
        tbl.push_back(V(0, 0, 1,1,32'hB1,       0, 1, 1, 0, 0, 0, 1));
        tbl.push_back(V(0, 0, 1,2,32'hB2,       0, 1, 1, 0, 0, 0, 1));
        tbl.push_back(V(0, 0, 1,3,32'hB3,       0, 1, 1, 0, 0, 0, 1));
        tbl.push_back(V(0, 0, 0,0,0,            0, 0, 1, 0, 0, 1, 1));
        // simultaneous push and retire at count 2
        tbl.push_back(V(1, 4, 0,0,0,            1, 0, 0, 1, 0, 0, 1));
        tbl.push_back(V(1, 5, 0,0,0,            1, 0, 0, 2, 0, 0, 1));
        tbl.push_back(V(0, 0, 1,0,32'hC0,       0, 1, 0, 2, 0, 0, 1));
        tbl.push_back(V(1, 6, 0,0,0,            1, 0, 1, 3, 0, 0, 1));
        tbl.push_back(V(0, 0, 1,1,32'hC1,       0, 1, 0, 3, 0, 0, 1));
        tbl.push_back(V(0, 0, 1,2,32'hC2,       0, 1, 1, 3, 0, 0, 1));
        tbl.push_back(V(0, 0, 0,0,0,            0, 0, 1, 3, 0, 1, 1));
        tbl.push_back(V(0, 0, 0,0,0,            0, 0, 0, 3, 0, 1, 1));

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // bad completions: invalid tag, then a done tag completed twice
        do_reset();
        step(V(0, 0, 1,2,32'h55,     0, 0, 0, 0, 0, 1, 1), "bad_invalid");
        step(V(1, 8, 0,0,0,          1, 0, 0, 1, 0, 0, 1), "bad_iss8");
        step(V(1, 9, 0,0,0,          1, 0, 0, 2, 0, 0, 1), "bad_iss9");
        step(V(0, 0, 1,1,32'h1111,   0, 1, 0, 2, 0, 0, 1), "bad_cmp1");
        step(V(0, 0, 1,1,32'h2222,   0, 0, 0, 2, 0, 0, 1), "bad_cmp1_again");
        step(V(0, 0, 1,0,32'h8888,   0, 1, 0, 2, 0, 0, 1), "bad_cmp0");
        step(V(0, 0, 0,0,0,          0, 0, 1, 2, 0, 0, 1), "bad_ret8");
        step(V(0, 0, 0,0,0,          0, 0, 1, 2, 0, 1, 1), "bad_ret9");

        // reset mid-flight: three pending, one done but blocked behind head
        step(V(1, 1, 0,0,0,          1, 0, 0, 3, 0, 0, 1), "mid_iss1");
        step(V(1, 2, 0,0,0,          1, 0, 0, 0, 0, 0, 1), "mid_iss2");
        step(V(1, 3, 0,0,0,          1, 0, 0, 1, 0, 0, 1), "mid_iss3");
        step(V(0, 0, 1,3,32'h77,     0, 1, 0, 1, 0, 0, 1), "mid_cmp");
        #3;
        rst = 1'b0;
        #1;
        chk_reset_outputs("mid_rst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        sb_q.delete();
        m_tag = 2'd0;
        for (int i = 0; i < 5; i++) begin
            step(V(0, 0, 0,0,0,      0, 0, 0, 0, 0, 1, 0), $sformatf("post_rst%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
